// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer sitting in front of a combinational 8-bit ALU.
// Owns a 4-entry register file and accepts one 16-bit instruction at a time over valid/ready.
module alu_sequencer #(
  parameter int          DATA_W      = 8,
  parameter logic [3:0]  NOP_OPCODE  = 4'hF,
  parameter int          EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flag,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              illegal,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         instr_q;
  logic [3:0]          exec_cnt;
  logic [DATA_W-1:0]   regs [4];
  logic [DATA_W-1:0]   cap_out;
  logic [3:0]          cap_flag;

  logic [3:0]          op;
  logic [1:0]          rd;
  logic [1:0]          rs1;
  logic [1:0]          rs2;
  logic [DATA_W-1:0]   imm;
  logic                is_alu;
  logic                is_ldi;
  logic                is_nop;
  logic                exec_last;

  assign op        = instr_q[15:12];
  assign rd        = instr_q[11:10];
  assign rs1       = instr_q[9:8];
  assign rs2       = instr_q[7:6];
  assign imm       = DATA_W'(instr_q[7:0]);
  assign is_alu    = (op <= 4'd6);
  assign is_ldi    = (op == 4'h8);
  assign is_nop    = (op == 4'hF);
  assign exec_last = (exec_cnt == 4'(EXEC_CYCLES - 1));
  assign dbg_data  = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ:    state_nxt = is_alu ? EXEC : WB;
      EXEC:    if (exec_last) state_nxt = WB;
      WB: begin
        done      = 1'b1;
        illegal   = ~(is_alu | is_ldi | is_nop);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are sampled once in READ and held, so a/b stay stable for the whole EXEC window.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= '0;
      exec_cnt   <= '0;
      alu_opcode <= NOP_OPCODE;
      alu_a      <= '0;
      alu_b      <= '0;
      cap_out    <= '0;
      cap_flag   <= '0;
      result     <= '0;
      flags      <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (instr_valid) instr_q <= instr;
        READ: begin
          alu_a    <= regs[rs1];
          alu_b    <= regs[rs2];
          exec_cnt <= '0;
          if (is_alu) alu_opcode <= op;
        end
        EXEC: begin
          if (exec_last) begin
            cap_out    <= alu_out;
            cap_flag   <= alu_flag;
            alu_opcode <= NOP_OPCODE;
          end else begin
            exec_cnt <= exec_cnt + 4'd1;
          end
        end
        WB: begin
          if (is_alu) begin
            regs[rd] <= cap_out;
            result   <= cap_out;
            flags    <= cap_flag;
          end else if (is_ldi) begin
            regs[rd] <= imm;
            result   <= imm;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU on the ALU ports, instruction-level register model,
// directed scenarios plus a randomized instruction stream.
module tb_alu_sequencer;

  localparam int EXEC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flag;
  logic        done;
  logic [7:0]  result;
  logic [3:0]  flags;
  logic        illegal;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int total = 0;
  int bad = 0;

  logic [7:0] mregs [4];
  logic [7:0] mresult;
  logic [3:0] mflags;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(8), .NOP_OPCODE(4'hF), .EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flag(alu_flag), .done(done), .result(result),
    .flags(flags), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Flag word is {carry, negative, zero, 0}; returns {flag, out}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] o;
    logic       c;
    logic       n;
    s = '0; o = '0; c = 1'b0; n = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8]; end
      4'd1: begin o = a - b; n = (a < b); end
      4'd2: o = a & b;
      4'd3: o = a | b;
      4'd4: o = a ^ b;
      4'd5: begin o = {a[6:0], 1'b0}; c = a[7]; end
      4'd6: begin o = {1'b0, a[7:1]}; c = a[0]; end
      default: o = '0;
    endcase
    return {c, n, (o == 8'd0), 1'b0, o};
  endfunction

  always_comb {alu_flag, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  function automatic bit op_is_alu(input logic [3:0] op);
    return op <= 4'd6;
  endfunction

  function automatic bit op_is_illegal(input logic [3:0] op);
    return !(op <= 4'd6 || op == 4'h8 || op == 4'hF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    mresult = '0;
    mflags  = '0;
  endtask

  task automatic model_apply(input logic [15:0] ins);
    logic [11:0] r;
    if (op_is_alu(ins[15:12])) begin
      r = alu_fn(ins[15:12], mregs[ins[9:8]], mregs[ins[7:6]]);
      mregs[ins[11:10]] = r[7:0];
      mresult = r[7:0];
      mflags  = r[11:8];
    end else if (ins[15:12] == 4'h8) begin
      mregs[ins[11:10]] = ins[7:0];
      mresult = ins[7:0];
    end
  endtask

  // Starts and ends at a negedge; the caller's instruction is accepted on the next free posedge.
  task automatic send(input logic [15:0] ins, input bit keep, output int lat, output bit ill,
                      output int opc, output logic [7:0] sa, output logic [7:0] sb,
                      output bit rdy_ok, output bit tmo);
    int n;
    n = 0; lat = 0; ill = 0; opc = 0; sa = '0; sb = '0; rdy_ok = 1; tmo = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin tmo = 1; instr_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    instr = 16'($urandom);
    instr_valid = keep;
    lat = 1;
    while (!done && lat < 40) begin
      if (instr_ready) rdy_ok = 0;
      if (alu_opcode == ins[15:12]) begin opc++; sa = alu_a; sb = alu_b; end
      @(negedge clk);
      lat++;
    end
    if (!done) tmo = 1;
    ill = illegal;
    if (instr_ready) rdy_ok = 0;
    @(negedge clk);
    if (!instr_ready) rdy_ok = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %0h want 1", instr_ready); end
    total++; if (alu_opcode !== 4'hF) begin bad++; $display("[TB] FAIL reset_opcode: got %0h want f", alu_opcode); end
    total++; if ({alu_a, alu_b} !== 16'h0) begin bad++; $display("[TB] FAIL reset_ab: got %0h want 0", {alu_a, alu_b}); end
    total++; if ({done, illegal} !== 2'b00) begin bad++; $display("[TB] FAIL reset_pulses: got %0h want 0", {done, illegal}); end
    total++; if ({result, flags} !== 12'h0) begin bad++; $display("[TB] FAIL reset_result_flags: got %0h want 0", {result, flags}); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      total++; if (dbg_data !== 8'h0) begin bad++; $display("[TB] FAIL reset_R%0d: got %0h want 0", i, dbg_data); end
    end
  endtask

  // Runs one instruction and checks latency, illegal, ALU presentation and architectural state.
  task automatic test_one(input string name, input logic [15:0] ins);
    int lat, opc;
    bit ill, rok, tmo;
    logic [7:0] sa, sb, ea, eb;
    logic [3:0] op;
    op = ins[15:12];
    ea = mregs[ins[9:8]];
    eb = mregs[ins[7:6]];
    send(ins, 1'b0, lat, ill, opc, sa, sb, rok, tmo);
    model_apply(ins);
    total++; if (tmo) begin bad++; $display("[TB] FAIL %s_timeout: got timeout want done", name); return; end
    total++; if (lat !== (op_is_alu(op) ? 2 + EXEC : 2)) begin bad++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, lat, op_is_alu(op) ? 2 + EXEC : 2); end
    total++; if (ill !== op_is_illegal(op)) begin bad++; $display("[TB] FAIL %s_illegal: got %0d want %0d", name, ill, op_is_illegal(op)); end
    if (op_is_alu(op)) begin
      total++; if (opc !== EXEC) begin bad++; $display("[TB] FAIL %s_opcode_cycles: got %0d want %0d", name, opc, EXEC); end
      total++; if ({sa, sb} !== {ea, eb}) begin bad++; $display("[TB] FAIL %s_operands: got %0h want %0h", name, {sa, sb}, {ea, eb}); end
    end else if (op != 4'hF) begin
      total++; if (opc !== 0) begin bad++; $display("[TB] FAIL %s_opcode_cycles: got %0d want 0", name, opc); end
    end
    total++; if (result !== mresult) begin bad++; $display("[TB] FAIL %s_result: got %0h want %0h", name, result, mresult); end
    total++; if (flags !== mflags) begin bad++; $display("[TB] FAIL %s_flags: got %0h want %0h", name, flags, mflags); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      total++; if (dbg_data !== mregs[i]) begin bad++; $display("[TB] FAIL %s_R%0d: got %0h want %0h", name, i, dbg_data, mregs[i]); end
    end
  endtask

  task automatic test_ldi();
    test_one("ldi_r1", {4'h8, 2'd1, 2'd0, 8'hF0});
    total++; if (mregs[1] !== 8'hF0 || result !== 8'hF0) begin bad++; $display("[TB] FAIL ldi_r1_value: got %0h want f0", result); end
    test_one("ldi_r2", {4'h8, 2'd2, 2'd0, 8'h20});
    total++; if (result !== 8'h20) begin bad++; $display("[TB] FAIL ldi_r2_value: got %0h want 20", result); end
  endtask

  task automatic test_alu_ops();
    test_one("add_r3", {4'h0, 2'd3, 2'd1, 2'd2, 6'd0});
    total++; if ({result, flags} !== {8'h10, 4'b1000}) begin bad++; $display("[TB] FAIL add_known: got %0h want 108", {result, flags}); end
    test_one("sub_zero", {4'h1, 2'd0, 2'd2, 2'd2, 6'd0});
    total++; if ({result, flags} !== {8'h00, 4'b0010}) begin bad++; $display("[TB] FAIL sub_zero_known: got %0h want 2", {result, flags}); end
    test_one("sub_neg", {4'h1, 2'd0, 2'd2, 2'd1, 6'd0});
    total++; if ({result, flags} !== {8'h30, 4'b0100}) begin bad++; $display("[TB] FAIL sub_neg_known: got %0h want 304", {result, flags}); end
  endtask

  task automatic test_illegal();
    test_one("illegal_a", {4'hA, 2'd3, 2'd1, 2'd2, 6'h3F});
    test_one("illegal_7", {4'h7, 2'd1, 2'd0, 8'h55});
    test_one("nop", {4'hF, 2'd2, 2'd1, 8'hAA});
  endtask

  task automatic test_back_to_back();
    int lat, opc;
    bit ill, rok, tmo;
    logic [7:0] sa, sb;
    logic [15:0] ins;
    for (int k = 0; k < 8; k++) begin
      ins = (k % 2 == 0) ? {4'h8, 2'(k), 2'd0, 8'($urandom)} : {4'($urandom_range(0, 6)), 12'($urandom)};
      send(ins, 1'b1, lat, ill, opc, sa, sb, rok, tmo);
      model_apply(ins);
      total++; if (tmo) begin bad++; $display("[TB] FAIL b2b_timeout_%0d: got timeout want done", k); instr_valid = 1'b0; return; end
      total++; if (!rok) begin bad++; $display("[TB] FAIL b2b_ready_%0d: got wrong ready window want low until after done", k); end
      total++; if (lat !== (op_is_alu(ins[15:12]) ? 2 + EXEC : 2)) begin bad++; $display("[TB] FAIL b2b_latency_%0d: got %0d want %0d", k, lat, op_is_alu(ins[15:12]) ? 2 + EXEC : 2); end
      total++; if (result !== mresult) begin bad++; $display("[TB] FAIL b2b_result_%0d: got %0h want %0h", k, result, mresult); end
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      total++; if (dbg_data !== mregs[i]) begin bad++; $display("[TB] FAIL b2b_R%0d: got %0h want %0h", i, dbg_data, mregs[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int k = 0; k < 30; k++) begin
      ins = 16'($urandom);
      test_one($sformatf("rand%0d", k), ins);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 0;
    instr = {4'h0, 2'd3, 2'd1, 2'd2, 6'd0};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    total++; if (alu_opcode !== 4'h0) begin bad++; $display("[TB] FAIL mid_exec_opcode: got %0h want 0", alu_opcode); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    total++; if (alu_opcode !== 4'hF) begin bad++; $display("[TB] FAIL mid_reset_opcode: got %0h want f", alu_opcode); end
    total++; if (instr_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_idle: got %0h want 2", {instr_ready, done}); end
    for (int c = 0; c < 5; c++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    total++; if (saw_done) begin bad++; $display("[TB] FAIL mid_reset_no_done: got done want none"); end
    total++; if ({result, flags} !== 12'h0) begin bad++; $display("[TB] FAIL mid_reset_result_flags: got %0h want 0", {result, flags}); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      total++; if (dbg_data !== 8'h0) begin bad++; $display("[TB] FAIL mid_reset_R%0d: got %0h want 0", i, dbg_data); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_ldi();
    test_alu_ops();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_ldi();
    test_alu_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
